// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam int KSIZE = 3;
    localparam int TAPS  = 9;

    // Clamp a scaled accumulator to the unsigned 8-bit output range.
    function automatic logic [7:0] relu_sat8(input logic signed [31:0] val);
        logic [7:0] res;
        if (val < 32'sd0) begin
            res = 8'd0;
        end else if (val > 32'sd255) begin
            res = 8'd255;
        end else begin
            res = val[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One filter lane: accumulates pixel*weight per tap and, on the last tap,
// latches the biased, scaled, rectified and saturated result.
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              last_tap,
    input  logic [7:0]        pix,
    input  logic signed [7:0] wgt,
    input  logic signed [7:0] bias,
    output logic [7:0]        result
);

    logic signed [ACC_W-1:0] acc_r;
    logic [7:0]              result_r;
    logic signed [16:0]      prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] scaled_s;

    // The final sum folds in the last tap so the result is ready as EMIT starts.
    assign prod_s     = 17'($signed({1'b0, pix})) * 17'(wgt);
    assign prod_ext_s = ACC_W'(prod_s);
    assign bias_ext_s = ACC_W'(bias) <<< SHIFT;
    assign sum_s      = acc_r + prod_ext_s + bias_ext_s;
    assign scaled_s   = sum_s >>> SHIFT;
    assign result     = result_r;

    // Accumulator and registered lane result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            result_r <= 8'd0;
        end else if (ena) begin
            if (clr) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (acc_en) begin
                if (last_tap) begin
                    result_r <= relu_sat8(32'(scaled_s));
                    acc_r    <= {ACC_W{1'b0}};
                end else begin
                    acc_r <= acc_r + prod_ext_s;
                end
            end
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 same-padded convolution: buffers one raster image, then
// emits NUM_FILT filter results per pixel position over a valid/ready port.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int NUM_FILT = 2,
    parameter int SHIFT    = 3,
    parameter int ACC_W    = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [7:0]                    pix_data,
    input  logic                          wgt_we,
    input  logic [$clog2(NUM_FILT*10)-1:0] wgt_addr,
    input  logic [7:0]                    wgt_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FILT*8-1:0]         out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int PW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int AW   = $clog2(NUM_FILT*10);

    state_t            state_r;
    logic [PW-1:0]     pix_cnt_r;
    logic [PW-1:0]     pos_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [3:0]        tap_r;
    logic [1:0]        kx_r;
    logic [1:0]        ky_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              busy_r;
    logic              done_r;
    logic [7:0]        buf_r [NPIX];
    logic signed [7:0] wgt_r [NUM_FILT][TAPS];
    logic signed [7:0] bias_r [NUM_FILT];

    logic              last_pix_s;
    logic              last_pos_s;
    logic              clr_s;
    logic              acc_en_s;
    logic              last_tap_s;
    logic [PW-1:0]     rd_addr_s;
    logic [7:0]        tap_pix_s;
    int                nx_s;
    int                ny_s;

    assign last_pix_s = (pix_cnt_r == PW'(NPIX-1));
    assign last_pos_s = (pos_r == PW'(NPIX-1));
    assign last_tap_s = (tap_r == 4'(TAPS-1));
    assign acc_en_s   = ena && (state_r == ST_MAC);
    assign clr_s      = ena && (((state_r == ST_LOAD) && pix_valid && last_pix_s) ||
                                ((state_r == ST_EMIT) && out_ready && !last_pos_s));

    assign pix_ready = ena && (state_r == ST_LOAD);
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Neighbour fetch with zero padding outside the image.
    always_comb begin
        nx_s      = int'(x_r) + int'(kx_r) - 32'sd1;
        ny_s      = int'(y_r) + int'(ky_r) - 32'sd1;
        rd_addr_s = {PW{1'b0}};
        tap_pix_s = 8'd0;
        if ((nx_s >= 0) && (nx_s < IMG_W) && (ny_s >= 0) && (ny_s < IMG_H)) begin
            rd_addr_s = PW'(ny_s * IMG_W + nx_s);
            tap_pix_s = buf_r[rd_addr_s];
        end else begin
            rd_addr_s = {PW{1'b0}};
            tap_pix_s = 8'd0;
        end
    end

    // Pixel buffer; entries are simply overwritten by each new image.
    always_ff @(posedge clk) begin
        if (rst_n && ena && (state_r == ST_LOAD) && pix_valid) begin
            buf_r[pix_cnt_r] <= pix_data;
        end
    end

    // Weight and bias registers, writable only while idle in LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FILT; f++) begin
                for (int k = 0; k < TAPS; k++) begin
                    wgt_r[f][k] <= 8'sd0;
                end
                bias_r[f] <= 8'sd0;
            end
        end else if (ena && wgt_we && (state_r == ST_LOAD)) begin
            for (int f = 0; f < NUM_FILT; f++) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (wgt_addr == AW'(f*10 + k)) begin
                        wgt_r[f][k] <= wgt_data;
                    end
                end
                if (wgt_addr == AW'(f*10 + 9)) begin
                    bias_r[f] <= wgt_data;
                end
            end
        end
    end

    // Control FSM: load image, sweep taps per position, hand out results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            pix_cnt_r   <= {PW{1'b0}};
            pos_r       <= {PW{1'b0}};
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            tap_r       <= 4'd0;
            kx_r        <= 2'd0;
            ky_r        <= 2'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (ena) begin
            done_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (pix_valid) begin
                        if (last_pix_s) begin
                            state_r   <= ST_MAC;
                            pix_cnt_r <= {PW{1'b0}};
                            pos_r     <= {PW{1'b0}};
                            x_r       <= {XW{1'b0}};
                            y_r       <= {YW{1'b0}};
                            tap_r     <= 4'd0;
                            kx_r      <= 2'd0;
                            ky_r      <= 2'd0;
                            busy_r    <= 1'b1;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + PW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (last_tap_s) begin
                        state_r     <= ST_EMIT;
                        out_valid_r <= 1'b1;
                        out_last_r  <= last_pos_s;
                        tap_r       <= 4'd0;
                        kx_r        <= 2'd0;
                        ky_r        <= 2'd0;
                    end else begin
                        tap_r <= tap_r + 4'd1;
                        if (kx_r == 2'(KSIZE-1)) begin
                            kx_r <= 2'd0;
                            ky_r <= ky_r + 2'd1;
                        end else begin
                            kx_r <= kx_r + 2'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (last_pos_s) begin
                            state_r   <= ST_LOAD;
                            pix_cnt_r <= {PW{1'b0}};
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            state_r <= ST_MAC;
                            pos_r   <= pos_r + PW'(1);
                            if (x_r == XW'(IMG_W-1)) begin
                                x_r <= {XW{1'b0}};
                                y_r <= y_r + YW'(1);
                            end else begin
                                x_r <= x_r + XW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_FILT; g++) begin : g_lane
            conv_mac_lane #(
                .ACC_W (ACC_W),
                .SHIFT (SHIFT)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .ena      (ena),
                .clr      (clr_s),
                .acc_en   (acc_en_s),
                .last_tap (last_tap_s),
                .pix      (tap_pix_s),
                .wgt      (wgt_r[g][tap_r]),
                .bias     (bias_r[g]),
                .result   (out_data[g*8 +: 8])
            );
        end
    endgenerate

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine (8x8 image, 2 filters, SHIFT=3).
module tb_conv2d_stream_engine;

    localparam int NF   = 2;
    localparam int NPIX = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        wgt_we;
    logic [4:0]  wgt_addr;
    logic [7:0]  wgt_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    logic [7:0]        img [NPIX];
    logic signed [7:0] mw  [NF][9];
    logic signed [7:0] mb  [NF];
    logic [16:0]       sb_q [$];

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    conv2d_stream_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .wgt_we    (wgt_we),
        .wgt_addr  (wgt_addr),
        .wgt_data  (wgt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Reference: same-padded 3x3 convolution, bias<<3, >>>3, ReLU, clamp.
    function automatic logic [16:0] model_out(input int p);
        logic [16:0] res;
        int x, y, nx, ny, s;
        res = 17'd0;
        x = p % 8;
        y = p / 8;
        for (int f = 0; f < NF; f++) begin
            s = 0;
            for (int k = 0; k < 9; k++) begin
                nx = x + (k % 3) - 1;
                ny = y + (k / 3) - 1;
                if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
                    s += int'(img[ny*8 + nx]) * int'(mw[f][k]);
            end
            s += int'(mb[f]) * 8;
            s = s >>> 3;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            res[f*8 +: 8] = 8'(s);
        end
        res[16] = (p == NPIX-1);
        return res;
    endfunction

    task automatic write_wgt(input int f, input int k, input logic [7:0] v);
        @(negedge clk);
        wgt_we   = 1'b1;
        wgt_addr = 5'(f*10 + k);
        wgt_data = v;
        @(negedge clk);
        wgt_we   = 1'b0;
    endtask

    task automatic set_filter(input int f, input int w, input int b);
        for (int k = 0; k < 9; k++) begin
            write_wgt(f, k, 8'(w));
            mw[f][k] = 8'(w);
        end
        write_wgt(f, 9, 8'(b));
        mb[f] = 8'(b);
    endtask

    task automatic set_random_filters();
        int b;
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < 9; k++) begin
                mw[f][k] = 8'($urandom_range(0, 255));
                write_wgt(f, k, mw[f][k]);
            end
            b = int'($urandom_range(0, 40)) - 20;
            mb[f] = 8'(b);
            write_wgt(f, 9, mb[f]);
        end
    endtask

    task automatic fill_img(input int mode, input int val);
        for (int i = 0; i < NPIX; i++)
            img[i] = (mode == 0) ? 8'(val) : 8'($urandom_range(0, 255));
    endtask

    // Streams img; returns at the negedge that presents the last pixel.
    task automatic load_image(input bit push);
        int cnt;
        @(negedge clk);
        cnt = 0;
        while (pix_ready !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL pix_ready_wait: pix_ready=%b, required 1", pix_ready);
        end
        for (int i = 0; i < NPIX; i++) begin
            if (i > 0) @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = img[i];
        end
        if (push)
            for (int p = 0; p < NPIX; p++) sb_q.push_back(model_out(p));
    endtask

    // Collects one image; optional output stall, ena pause and wgt_we pulses.
    task automatic collect_image(input int stall_pos, input int ena_pos, input int wgt_pos);
        int          cnt;
        int          lat_exp;
        logic [16:0] exp_v;
        logic [15:0] held;
        for (int p = 0; p < NPIX; p++) begin
            cnt     = 0;
            lat_exp = (p == ena_pos) ? 15 : 10;
            do begin
                @(negedge clk);
                pix_valid = 1'b0;
                cnt++;
                if (p == ena_pos) begin
                    if (cnt == 3) ena = 1'b0;
                    else if (cnt == 8) ena = 1'b1;
                end
                if (p == wgt_pos) begin
                    if (cnt == 2) begin
                        wgt_we = 1'b1; wgt_addr = 5'd0; wgt_data = 8'h55;
                    end else if (cnt == 4) begin
                        wgt_addr = 5'd19; wgt_data = 8'h7f;
                    end else if (cnt == 6) begin
                        wgt_we = 1'b0;
                    end
                end
            end while (out_valid !== 1'b1 && cnt < 60);
            checks++;
            if (cnt != lat_exp) begin
                errors++;
                $display("FAIL latency pos %0d: got %0d cycles, required %0d", p, cnt, lat_exp);
            end
            exp_v = 17'd0;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty pos %0d: got output, required none", p);
            end else begin
                exp_v = sb_q.pop_front();
            end
            checks++;
            if (out_data !== exp_v[15:0]) begin
                errors++;
                $display("FAIL out_data pos %0d: got %h, required %h", p, out_data, exp_v[15:0]);
            end
            checks++;
            if (out_last !== exp_v[16]) begin
                errors++;
                $display("FAIL out_last pos %0d: got %b, required %b", p, out_last, exp_v[16]);
            end
            if (p == stall_pos) begin
                out_ready = 1'b0;
                held      = out_data;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== held) begin
                        errors++;
                        $display("FAIL stall_hold pos %0d: got valid=%b data=%h, required valid=1 data=%h",
                                 p, out_valid, out_data, held);
                    end
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL end_of_image: got done=%b valid=%b pix_ready=%b busy=%b, required 1 0 1 0",
                     done, out_valid, pix_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got done=%b pix_ready=%b, required 0 1", done, pix_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; pix_valid = 1'b0; pix_data = 8'd0;
        wgt_we = 1'b0; wgt_addr = 5'd0; wgt_data = 8'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 ||
            out_last !== 1'b0 || done !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b data=%h last=%b done=%b ready=%b, required 0 0 0000 0 0 1",
                     busy, out_valid, out_data, out_last, done, pix_ready);
        end
        rst_n = 1'b1;
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < 9; k++) mw[f][k] = 8'sd0;
            mb[f] = 8'sd0;
        end
    endtask

    // Pixels 8 with SHIFT 3 gives corner 4, edge 6, interior 9; filter 1 all -1 -> 0.
    task automatic test_padding();
        set_filter(0, 1, 0);
        set_filter(1, -1, 0);
        fill_img(0, 8);
        load_image(1'b1);
        collect_image(-1, -1, -1);
    endtask

    task automatic test_saturation();
        set_filter(0, 127, 0);
        set_filter(1, -1, 0);
        fill_img(0, 255);
        load_image(1'b1);
        collect_image(-1, -1, -1);
    endtask

    task automatic test_bias();
        set_filter(0, 0, 13);
        set_filter(1, 0, 13);
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(-1, -1, -1);
    endtask

    task automatic test_stalls();
        set_random_filters();
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(5, 7, -1);
    endtask

    task automatic test_wgt_while_busy();
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(-1, -1, 2);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_seen;
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(-1, -1, -1);
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(-1, -1, -1);
        checks++;
        if (done_seen - d0 != 2) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, required 2", done_seen - d0);
        end
    endtask

    task automatic test_reset_mid_mac();
        fill_img(1, 0);
        load_image(1'b0);
        repeat (4) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mac: got busy=%b valid=%b pix_ready=%b, required 0 0 1",
                     busy, out_valid, pix_ready);
        end
        rst_n = 1'b1;
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < 9; k++) mw[f][k] = 8'sd0;
            mb[f] = 8'sd0;
        end
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(-1, -1, -1);
        set_random_filters();
        fill_img(1, 0);
        load_image(1'b1);
        collect_image(-1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_padding();
        test_saturation();
        test_bias();
        test_stalls();
        test_wgt_while_busy();
        test_back_to_back();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv2d_stream_engine.md
CONV2D_STREAM_ENGINE -- requirements
Module: conv2d_stream_engine

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 8: image height in pixels (>=3).
REQ-003 Parameter NUM_FILT, default 2: number of 3x3 filters computed in parallel.
REQ-004 Parameter SHIFT, default 3: arithmetic right shift applied before ReLU/saturation.
REQ-005 Parameter ACC_W, default 20: signed accumulator width.
REQ-006 clk  in  1: single clock, all logic on rising edge.
REQ-007 rst_n  in  1: synchronous reset, active low.
REQ-008 ena  in  1: global enable; when low, all state, counters and registers hold.
REQ-009 pix_valid/pix_ready  in/out  1/1: pixel stream handshake, raster order.
REQ-010 pix_data  in  8: unsigned pixel.
REQ-011 wgt_we  in  1: weight/bias write strobe.
REQ-012 wgt_addr  in  clog2(NUM_FILT*10): filter f taps 0-8 at f*10+k, bias at f*10+9.
REQ-013 wgt_data  in  8: signed weight or bias.
REQ-014 out_valid/out_ready  out/in  1/1: result handshake.
REQ-015 out_data  out  NUM_FILT*8: filter f result in bits [f*8+7:f*8].
REQ-016 out_last  out  1: high with the final position of an image.
REQ-017 busy  out  1: high in MAC or EMIT state.
REQ-018 done  out  1: one-cycle pulse after the last result transfers.

Function
REQ-019 States: LOAD, MAC, EMIT; transfers on either handshake occur only when ena=1.
REQ-020 LOAD: pix_ready=ena; each transfer writes buffer[pix_cnt]; after transfer of pixel IMG_W*IMG_H-1, next state MAC with pos=0, tap=0, accumulators cleared.
REQ-021 MAC: one tap per cycle, tap 0..8 row-major over (x-1..x+1, y-1..y+1); all NUM_FILT lanes accumulate pixel*weight (unsigned 8 x signed 8, sign-extended to ACC_W) in the same cycle.
REQ-022 Same padding: taps outside the image contribute pixel 0; output count is IMG_W*IMG_H, pos = y*IMG_W+x.
REQ-023 After tap 8, next state EMIT; out_data registered as sat(relu((acc + (bias<<SHIFT)) >>> SHIFT)): negative -> 0, >255 -> 255.
REQ-024 EMIT: out_valid=1, out_data and out_last stable until transfer; out_ready low stalls indefinitely.
REQ-025 EMIT transfer, non-final pos: next state MAC, pos+1, accumulators cleared, out_valid=0.
REQ-026 EMIT transfer, final pos: next state LOAD, pix_cnt=0, done=1 for one cycle, out_valid=0.
REQ-027 Latency: first out_valid exactly 10 cycles after last-pixel transfer; 10 cycles per position with out_ready high and ena high.
REQ-028 wgt_we honoured only in LOAD; ignored when busy=1. Weights persist across images.
REQ-029 Pixel buffer is not cleared between images; every entry is overwritten before use.

Reset
REQ-030 rst_n=0 at a clock edge: state LOAD, pix_cnt/pos/tap=0, accumulators 0, out_valid=0, out_data=0, out_last=0, done=0, busy=0, pix_ready=ena; all weights and biases 0; any in-flight image is discarded.

Structure
REQ-031 Package conv_pkg holds the state enum, KSIZE=3, TAPS=9, and the saturate/ReLU function.
REQ-032 One sub-module conv_mac_lane (per filter: accumulator, clear, accumulate, scale/ReLU/saturate), instantiated NUM_FILT times in a generate loop.

Verification
REQ-033 All pixels 1, filter 0 weights all 1, bias 0, SHIFT=0 -> corner 4, edge 6, interior 9; out_last only on pos 63.
REQ-034 All pixels 255, weights all 127, SHIFT=3 -> every interior output 255 (saturation); filter with all weights -1 -> all 0 (ReLU).
REQ-035 Bias 13, weights 0, SHIFT=3 -> every output 13.
REQ-036 out_ready low 5 cycles in EMIT -> out_data/out_valid stable, pos not advanced; ena low 5 cycles mid-MAC -> result identical, latency +5.
REQ-037 rst_n low during MAC -> next cycle busy=0, out_valid=0, pix_ready=1; a fresh 64-pixel image then yields correct results.
REQ-038 wgt_we pulses while busy -> weights unchanged; back-to-back images -> done pulses twice, pix_ready high the cycle after each done.
